// File: rtl/oled_glyph_blit.sv
// rtl/oled_glyph_blit.sv - glyph renderer merging font ROM columns into a page-mode OLED framebuffer
// Fetches one glyph column at a time, then read-modify-writes every framebuffer page it overlaps.
module oled_glyph_blit #(
  parameter int DISP_W     = 128,
  parameter int DISP_H     = 64,
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int FIRST_CHAR = 33,
  parameter int NUM_CHARS  = 94,
  parameter int ROM_AW     = 12,
  parameter int ROM_LAT    = 2,
  parameter int FB_LAT     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [7:0]                           ascii,
  input  logic [$clog2(DISP_W)-1:0]            x,
  input  logic [$clog2(DISP_H)-1:0]            y,
  input  logic                                 opaque,
  input  logic                                 invert,
  output logic                                 busy,
  output logic                                 done,
  output logic [ROM_AW-1:0]                    rom_addr,
  input  logic [7:0]                           rom_data,
  output logic [$clog2(DISP_W*DISP_H/8)-1:0]   fb_addr,
  output logic                                 fb_rd_en,
  input  logic [7:0]                           fb_rd_data,
  output logic                                 fb_wr_en,
  output logic [7:0]                           fb_wr_data
);
  localparam int XW    = $clog2(DISP_W);
  localparam int YW    = $clog2(DISP_H);
  localparam int AW    = $clog2(DISP_W*DISP_H/8);
  localparam int RW    = YW + 1;
  localparam int PGW   = RW - 3;
  localparam int BPC   = (GLYPH_H + 7) / 8;
  localparam int CW    = $clog2(GLYPH_W) + 1;
  localparam int PAGES = DISP_H / 8;
  localparam logic [8:0]     CH_LO  = 9'(FIRST_CHAR);
  localparam logic [8:0]     CH_HI  = 9'(FIRST_CHAR + NUM_CHARS - 1);
  localparam logic [XW:0]    W_LIM  = (XW+1)'(DISP_W);
  localparam logic [YW:0]    H_LIM  = (YW+1)'(DISP_H);
  localparam logic [PGW-1:0] PG_MAX = PGW'(PAGES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ROM_REQ, S_ROM_WAIT, S_ROM_CAP, S_PG_RD, S_PG_WAIT, S_PG_WR, S_NEXT_COL, S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_blank, r_opaque, r_invert;
  logic [7:0]         r_idx, r_wcnt, r_old;
  logic [RW-1:0]      r_y;
  logic [XW:0]        r_xc;
  logic [CW-1:0]      r_col;
  logic [1:0]         r_byte;
  logic [GLYPH_H-1:0] r_gcol;
  logic [PGW-1:0]     r_page, r_pg_last;

  logic               w_in_range, w_off_screen, w_last_col;
  logic [RW-1:0]      w_row_last, w_row;
  logic [PGW-1:0]     w_pg_last, w_pg_first;
  logic [XW:0]        w_xn;
  logic [4:0]         w_sh;
  logic [7:0]         w_rev, w_mask, w_gbits, w_merged;
  logic [31:0]        w_gpad;
  logic [ROM_AW-1:0]  w_rom_addr;
  logic [AW-1:0]      w_fb_addr;

  assign w_in_range   = ({1'b0, ascii} >= CH_LO) && ({1'b0, ascii} <= CH_HI);
  assign w_off_screen = ({1'b0, x} >= W_LIM) || ({1'b0, y} >= H_LIM);
  assign w_row_last   = {1'b0, y} + RW'(GLYPH_H - 1);
  assign w_pg_last    = (PGW'(w_row_last >> 3) > PG_MAX) ? PG_MAX : PGW'(w_row_last >> 3);
  assign w_pg_first   = PGW'(r_y >> 3);
  assign w_xn         = r_xc + (XW+1)'(1);
  assign w_last_col   = (r_col == CW'(GLYPH_W - 1)) || (w_xn >= W_LIM);
  assign w_sh         = {r_byte, 3'b000};
  assign w_gpad       = 32'(r_gcol);
  assign w_rom_addr   = ROM_AW'(32'(r_idx) * GLYPH_W * BPC + 32'(r_col) * BPC + 32'(r_byte));
  assign w_fb_addr    = AW'(32'(r_page) * DISP_W + 32'(r_xc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = w_off_screen ? S_DONE : (w_in_range ? S_ROM_REQ : S_PG_RD);
      S_ROM_REQ:  w_state_nxt = (ROM_LAT > 1) ? S_ROM_WAIT : S_ROM_CAP;
      S_ROM_WAIT: if (r_wcnt == 8'(ROM_LAT - 2)) w_state_nxt = S_ROM_CAP;
      S_ROM_CAP:  w_state_nxt = (r_byte == 2'(BPC - 1)) ? S_PG_RD : S_ROM_REQ;
      S_PG_RD:    w_state_nxt = S_PG_WAIT;
      S_PG_WAIT:  if (r_wcnt == 8'(FB_LAT - 1)) w_state_nxt = S_PG_WR;
      S_PG_WR:    w_state_nxt = (r_page == r_pg_last) ? S_NEXT_COL : S_PG_RD;
      S_NEXT_COL: w_state_nxt = w_last_col ? S_DONE : (r_blank ? S_PG_RD : S_ROM_REQ);
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 8; i++) w_rev[i] = rom_data[7-i];
  end

  // Byte bit b of the current page holds display row page*8 + (7-b); only glyph-box rows are touched.
  always_comb begin
    w_mask  = '0;
    w_gbits = '0;
    w_row   = '0;
    for (int b = 0; b < 8; b++) begin
      w_row = {r_page, 3'b000} + RW'(7 - b);
      if ((w_row >= r_y) && (w_row < r_y + RW'(GLYPH_H))) begin
        w_mask[b]  = 1'b1;
        w_gbits[b] = w_gpad[5'(w_row - r_y)] ^ r_invert;
      end
    end
    w_merged = r_opaque ? ((r_old & ~w_mask) | w_gbits) : (r_old | w_gbits);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank   <= 1'b0;
      r_opaque  <= 1'b0;
      r_invert  <= 1'b0;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_old     <= '0;
      r_y       <= '0;
      r_xc      <= '0;
      r_col     <= '0;
      r_byte    <= '0;
      r_gcol    <= '0;
      r_page    <= '0;
      r_pg_last <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_blank   <= !w_in_range;
          r_opaque  <= opaque;
          r_invert  <= invert;
          r_idx     <= ascii - CH_LO[7:0];
          r_y       <= {1'b0, y};
          r_xc      <= {1'b0, x};
          r_col     <= '0;
          r_byte    <= '0;
          r_gcol    <= '0;
          r_page    <= PGW'(y >> 3);
          r_pg_last <= w_pg_last;
        end
        S_ROM_REQ:  r_wcnt <= '0;
        S_ROM_WAIT: r_wcnt <= r_wcnt + 8'd1;
        S_ROM_CAP: begin
          r_gcol <= GLYPH_H'((w_gpad & ~(32'hFF << w_sh)) | ({24'd0, w_rev} << w_sh));
          r_byte <= (r_byte == 2'(BPC - 1)) ? 2'd0 : r_byte + 2'd1;
        end
        S_PG_RD:    r_wcnt <= '0;
        S_PG_WAIT: begin
          r_wcnt <= r_wcnt + 8'd1;
          if (r_wcnt == 8'(FB_LAT - 1)) r_old <= fb_rd_data;
        end
        S_PG_WR:    if (r_page != r_pg_last) r_page <= r_page + PGW'(1);
        S_NEXT_COL: if (!w_last_col) begin
          r_col  <= r_col + CW'(1);
          r_xc   <= w_xn;
          r_page <= w_pg_first;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    fb_rd_en   = (r_state == S_PG_RD);
    fb_wr_en   = (r_state == S_PG_WR);
    rom_addr   = (r_state == S_ROM_REQ || r_state == S_ROM_WAIT || r_state == S_ROM_CAP) ? w_rom_addr : '0;
    fb_addr    = (r_state == S_PG_RD || r_state == S_PG_WAIT || r_state == S_PG_WR) ? w_fb_addr : '0;
    fb_wr_data = (r_state == S_PG_WR) ? w_merged : '0;
  end
endmodule

// File: tb/tb_oled_glyph_blit.sv
// tb/tb_oled_glyph_blit.sv - bench for oled_glyph_blit with a pixel-level framebuffer model
// Instance u0 uses default parameters; u1 has a 120-pixel width and slower ROM/framebuffer.
module tb_oled_glyph_blit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1, opaque, invert;
  logic [7:0] ascii;
  logic [6:0] x;
  logic [5:0] y;
  logic       busy0, done0, rd_en0, wr_en0, busy1, done1, rd_en1, wr_en1;
  logic [11:0] rom_addr0, rom_addr1;
  logic [7:0]  rom_data0, rom_data1, rd_data0, rd_data1, wr_data0, wr_data1, rdq1;
  logic [9:0]  fb_addr0, fb_addr1;

  logic [7:0] rom [4096];
  logic [7:0] fb0 [1024];
  logic [7:0] fb1 [1024];
  logic [7:0] exp_fb [1024];
  logic [7:0] rp0 [2];
  logic [7:0] rp1 [3];

  int n_checks = 0;
  int n_pass   = 0;
  logic cur = 1'b0;

  oled_glyph_blit u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .ascii(ascii), .x(x), .y(y),
    .opaque(opaque), .invert(invert), .busy(busy0), .done(done0),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .fb_addr(fb_addr0), .fb_rd_en(rd_en0),
    .fb_rd_data(rd_data0), .fb_wr_en(wr_en0), .fb_wr_data(wr_data0)
  );

  oled_glyph_blit #(.DISP_W(120), .ROM_LAT(3), .FB_LAT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ascii(ascii), .x(x), .y(y),
    .opaque(opaque), .invert(invert), .busy(busy1), .done(done1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .fb_addr(fb_addr1), .fb_rd_en(rd_en1),
    .fb_rd_data(rd_data1), .fb_wr_en(wr_en1), .fb_wr_data(wr_data1)
  );

  always @(posedge clk) begin
    rp0[0] <= rom[rom_addr0];
    rp0[1] <= rp0[0];
    rp1[0] <= rom[rom_addr1];
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
    if (rd_en0) rd_data0 <= fb0[fb_addr0];
    if (rd_en1) rdq1 <= fb1[fb_addr1];
    rd_data1 <= rdq1;
  end
  assign rom_data0 = rp0[1];
  assign rom_data1 = rp1[2];

  wire       s_wr   = cur ? wr_en1 : wr_en0;
  wire       s_done = cur ? done1 : done0;
  wire [9:0] s_addr = cur ? fb_addr1 : fb_addr0;
  wire [7:0] s_data = cur ? wr_data1 : wr_data0;

  task automatic fill(input bit inst, input bit rnd, input logic [7:0] v);
    for (int i = 0; i < 1024; i++) begin
      if (inst) fb1[i] = rnd ? 8'($urandom) : v;
      else      fb0[i] = rnd ? 8'($urandom) : v;
    end
  endtask

  // Pixel-by-pixel reference: walk glyph rows/columns, place each pixel, count page writes and cycles.
  task automatic model(input bit inst, input logic [7:0] a, input int xx, input int yy,
                       input bit op, input bit inv, output int nwr, output int lat);
    int w, rl, fl, first, last;
    bit inr, b;
    w = inst ? 120 : 128;
    rl = inst ? 3 : 2;
    fl = inst ? 2 : 1;
    nwr = 0;
    lat = 1;
    inr = (a >= 8'd33) && (a <= 8'd126);
    if (xx >= w || yy >= 64) return;
    first = yy / 8;
    last = (yy + 15) / 8;
    if (last > 7) last = 7;
    for (int c = 0; c < 8; c++) begin
      if (xx + c >= w) break;
      nwr += last - first + 1;
      lat += (inr ? 2 * (rl + 1) : 0) + (last - first + 1) * (fl + 2) + 1;
      for (int r = 0; r < 16; r++) begin
        int yr, ad;
        yr = yy + r;
        if (yr >= 64) continue;
        b = inr ? rom[(int'(a) - 33) * 16 + c * 2 + r / 8][7 - (r % 8)] : 1'b0;
        b ^= inv;
        ad = (yr / 8) * w + xx + c;
        if (op) exp_fb[ad][7 - (yr % 8)] = b;
        else if (b) exp_fb[ad][7 - (yr % 8)] = 1'b1;
      end
    end
  endtask

  task automatic run_op(input bit inst, input string nm, input logic [7:0] a, input logic [6:0] xx,
                        input logic [5:0] yy, input bit op, input bit inv, input bit poke);
    int nwr_exp, lat_exp, nwr, ndone, cyc, diffs, bad_ad;
    cur = inst;
    for (int i = 0; i < 1024; i++) exp_fb[i] = inst ? fb1[i] : fb0[i];
    model(inst, a, int'(xx), int'(yy), op, inv, nwr_exp, lat_exp);
    @(negedge clk);
    ascii = a; x = xx; y = yy; opaque = op; invert = inv;
    if (inst) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    nwr = 0; ndone = 0; cyc = 0;
    while (ndone == 0 && cyc < 3000) begin
      if (poke && cyc == 5) begin
        x = xx + 7'd40; y = yy ^ 6'd9; ascii = 8'h5A; opaque = ~op;
        if (inst) start1 = 1'b1; else start0 = 1'b1;
      end
      if (poke && cyc == 6) begin start0 = 1'b0; start1 = 1'b0; end
      if (s_wr) begin
        if (inst) fb1[s_addr] = s_data; else fb0[s_addr] = s_data;
        nwr++;
      end
      if (s_done) ndone++;
      cyc++;
      if (ndone == 0) @(negedge clk);
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (s_wr) begin
        if (inst) fb1[s_addr] = s_data; else fb0[s_addr] = s_data;
        nwr++;
      end
      if (s_done) ndone++;
    end
    diffs = 0; bad_ad = 0;
    for (int i = 0; i < 1024; i++) begin
      if ((inst ? fb1[i] : fb0[i]) !== exp_fb[i]) begin
        if (diffs == 0) bad_ad = i;
        diffs++;
      end
    end
    n_checks++;
    if (ndone !== 1) $display("FAIL %s done_count: got %0d expected 1", nm, ndone);
    else n_pass++;
    n_checks++;
    if (nwr !== nwr_exp) $display("FAIL %s write_count: got %0d expected %0d", nm, nwr, nwr_exp);
    else n_pass++;
    n_checks++;
    if (diffs !== 0)
      $display("FAIL %s framebuffer: %0d bytes differ, addr %0d got %h expected %h", nm, diffs, bad_ad,
               inst ? fb1[bad_ad] : fb0[bad_ad], exp_fb[bad_ad]);
    else n_pass++;
    n_checks++;
    if (cyc !== lat_exp) $display("FAIL %s latency: got %0d expected %0d cycles", nm, cyc, lat_exp);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    ascii = '0; x = '0; y = '0; opaque = 1'b0; invert = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy0, done0, rd_en0, wr_en0, rom_addr0, fb_addr0, wr_data0} !== '0)
      $display("FAIL reset_u0: outputs %h expected 0", {busy0, done0, rd_en0, wr_en0, rom_addr0, fb_addr0, wr_data0});
    else n_pass++;
    n_checks++;
    if ({busy1, done1, rd_en1, wr_en1, rom_addr1, fb_addr1, wr_data1} !== '0)
      $display("FAIL reset_u1: outputs %h expected 0", {busy1, done1, rd_en1, wr_en1, rom_addr1, fb_addr1, wr_data1});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic(input bit inst);
    int bad, w;
    w = inst ? 120 : 128;
    fill(inst, 1'b0, 8'h00);
    run_op(inst, inst ? "slow_A" : "basic_A", 8'h41, 7'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if ((inst ? fb1[c] : fb0[c]) !== rom[32 * 16 + c * 2]) bad++;
      if ((inst ? fb1[w + c] : fb0[w + c]) !== rom[32 * 16 + c * 2 + 1]) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL rom_bytes_direct: %0d bytes wrong expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_unaligned;
    int bad;
    fill(1'b0, 1'b0, 8'hFF);
    run_op(1'b0, "unaligned_or", 8'h41, 7'd0, 6'd3, 1'b0, 1'b0, 1'b0);
    fill(1'b0, 1'b0, 8'hFF);
    run_op(1'b0, "unaligned_opaque", 8'h41, 7'd0, 6'd3, 1'b1, 1'b0, 1'b0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (fb0[c][7:5] !== 3'b111) bad++;
      if (fb0[256 + c][4:0] !== 5'h1F) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL unaligned_kept_bits: %0d bytes wrong expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_clip;
    fill(1'b0, 1'b1, 8'h00);
    run_op(1'b0, "clip_right", 8'h42, 7'd124, 6'd0, 1'b1, 1'b0, 1'b0);
    run_op(1'b0, "clip_bottom", 8'h43, 7'd0, 6'd56, 1'b0, 1'b1, 1'b0);
    fill(1'b1, 1'b1, 8'h00);
    run_op(1'b1, "clip_offscreen", 8'h44, 7'd125, 6'd5, 1'b1, 1'b0, 1'b0);
    run_op(1'b1, "clip_right_w120", 8'h45, 7'd116, 6'd61, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_blank;
    int bad;
    fill(1'b0, 1'b0, 8'h00);
    run_op(1'b0, "blank_inv", 8'h20, 7'd10, 6'd8, 1'b1, 1'b1, 1'b0);
    bad = 0;
    for (int c = 10; c < 18; c++) begin
      if (fb0[128 + c] !== 8'hFF) bad++;
      if (fb0[256 + c] !== 8'hFF) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL blank_box_ff: %0d bytes wrong expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_busy_start;
    fill(1'b0, 1'b1, 8'h00);
    run_op(1'b0, "start_while_busy", 8'h41, 7'd20, 6'd13, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 12; k++) begin
      bit inst;
      inst = k[0];
      fill(inst, 1'b1, 8'h00);
      run_op(inst, "random", 8'($urandom_range(20, 130)), 7'($urandom_range(0, 127)),
             6'($urandom_range(0, 63)), 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_mid(input bit in_wr);
    int n, nwr, ndone;
    cur = 1'b0;
    fill(1'b0, 1'b1, 8'h00);
    @(negedge clk);
    ascii = 8'h41; x = 7'd3; y = 6'd3; opaque = 1'b1; invert = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    if (in_wr) begin
      n = 0;
      while (!wr_en0 && n < 500) begin @(negedge clk); n++; end
      n_checks++;
      if (wr_en0 !== 1'b1) $display("FAIL reset_pg_wr_reached: wr_en %b expected 1", wr_en0);
      else n_pass++;
      if (wr_en0) fb0[fb_addr0] = wr_data0;
    end else begin
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy0, done0, rd_en0, wr_en0, rom_addr0, fb_addr0, wr_data0} !== '0)
      $display("FAIL reset_mid_%0d outputs: got %h expected 0", in_wr,
               {busy0, done0, rd_en0, wr_en0, rom_addr0, fb_addr0, wr_data0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0; ndone = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (wr_en0) nwr++;
      if (done0 || busy0) ndone++;
    end
    n_checks++;
    if (nwr !== 0 || ndone !== 0)
      $display("FAIL reset_mid_%0d activity: writes %0d busy/done cycles %0d expected 0", in_wr, nwr, ndone);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 2; i++) rp0[i] = '0;
    for (int i = 0; i < 3; i++) rp1[i] = '0;
    rd_data0 = '0; rd_data1 = '0; rdq1 = '0;
    fill(1'b0, 1'b0, 8'h00);
    fill(1'b1, 1'b0, 8'h00);
    test_reset;
    test_basic(1'b0);
    test_unaligned;
    test_clip;
    test_blank;
    test_busy_start;
    test_basic(1'b1);
    test_random;
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
